// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache: 16 lines x 32 B, tag [31:9], index [8:5], word [4:2].
// Latency: hits are combinational (no stall); a miss stalls for fill latency + 2 cycles, plus write-back latency when the victim is dirty.
// Backpressure: cpu_stall_o holds the pipeline while a miss is outstanding. Optional DCACHE_STATS_EN adds hit_cnt_o/miss_cnt_o.
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_t;

    state_t       state;
    logic [255:0] data_arr [16];
    logic [22:0]  tag_arr  [16];
    logic [15:0]  valid;
    logic [15:0]  dirty;

    logic         en_q;
    logic         wr_q;
    logic [31:0]  addr_q;
    logic [255:0] wdata_q;

    logic [22:0]  req_tag;
    logic [3:0]   req_idx;
    logic [2:0]   req_word;
    logic [7:0]   req_off;
    logic [31:0]  req_blk;
    logic         req;
    logic         is_store;
    logic         hit;
    logic         idle_hit;
    logic         idle_miss;
    logic         victim_dirty;
    logic [31:0]  rd_word;
    logic         unused_bits;

    assign req_tag      = cpu_addr_i[31:9];
    assign req_idx      = cpu_addr_i[8:5];
    assign req_word     = cpu_addr_i[4:2];
    assign req_off      = {req_word, 5'b0};
    assign req_blk      = {cpu_addr_i[31:5], 5'b0};
    assign unused_bits  = ^cpu_addr_i[1:0];

    // A write request wins when both request lines are high.
    assign req          = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_store     = cpu_MemWrite_i;
    assign hit          = req && valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign idle_hit     = (state == IDLE) && hit;
    assign idle_miss    = (state == IDLE) && req && !hit;
    assign victim_dirty = valid[req_idx] && dirty[req_idx];
    assign rd_word      = data_arr[req_idx][req_off +: 32];

    // Outputs are forced low while reset is asserted, not just after the reset edge.
    always_comb begin
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        if (rst_i) begin
            cpu_stall_o  = (state != IDLE) || idle_miss;
            cpu_data_o   = idle_hit ? rd_word : 32'h0;
            mem_enable_o = en_q;
            mem_write_o  = wr_q;
            mem_addr_o   = addr_q;
            mem_data_o   = wdata_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            valid   <= '0;
            dirty   <= '0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_hit && is_store) begin
                        data_arr[req_idx][req_off +: 32] <= cpu_data_i;
                        dirty[req_idx]                   <= 1'b1;
                    end else if (idle_miss) begin
                        en_q <= 1'b1;
                        if (victim_dirty) begin
                            state   <= WRITEBACK;
                            wr_q    <= 1'b1;
                            addr_q  <= {tag_arr[req_idx], req_idx, 5'b0};
                            wdata_q <= data_arr[req_idx];
                        end else begin
                            state   <= ALLOCATE;
                            wr_q    <= 1'b0;
                            addr_q  <= req_blk;
                            wdata_q <= '0;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state   <= ALLOCATE;
                        wr_q    <= 1'b0;
                        addr_q  <= req_blk;
                        wdata_q <= '0;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        data_arr[req_idx] <= mem_data_i;
                        tag_arr[req_idx]  <= req_tag;
                        valid[req_idx]    <= 1'b1;
                        dirty[req_idx]    <= 1'b0;
                        en_q              <= 1'b0;
                        addr_q            <= '0;
                        state             <= REFILL;
                    end
                end
                REFILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (idle_hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (idle_miss) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: transaction-level cache/memory model predicts every cycle's outputs.
// Directed reset/miss/hit/write-back/abort sequence, then randomized loads and stores.
module tb_dcache_controller;

    logic         clk;
    logic         rst_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    dcache_controller dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o      (hit_cnt),
        .miss_cnt_o     (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit           chk;
        bit           zero;
        bit           stall;
        bit           en;
        bit           wr;
        logic [31:0]  addr;
        bit           chk_wd;
        logic [255:0] wd;
        bit           chk_dat;
        logic [31:0]  dat;
    } exp_t;
    exp_t exp_c;

    // Cache and memory model: whole lines and whole blocks, no state machine.
    bit   [15:0]  m_valid;
    bit   [15:0]  m_dirty;
    logic [22:0]  m_tag  [16];
    logic [255:0] m_data [16];
    logic [255:0] mem [logic [31:0]];

    // Observations of the current request, pinned against literal values.
    int          obs_stall;
    bit          obs_first;
    bit          obs_first_stall;
    bit          obs_wb;
    logic [31:0] obs_wb_addr;
    logic [31:0] obs_wb_w1;
    bit          obs_alloc;
    logic [31:0] obs_alloc_addr;
    logic [31:0] obs_data;
    logic [31:0] obs_hits;
    logic [31:0] obs_miss;

    function automatic void ck(input string nm, input logic [255:0] act, input logic [255:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = rnd256();
        return mem[a];
    endfunction

    always @(negedge clk) begin
        if (exp_c.chk) begin
            if (exp_c.zero) begin
                ck("rst_stall", 256'(cpu_stall_o), 256'(0));
                ck("rst_en", 256'(mem_enable_o), 256'(0));
                ck("rst_wr", 256'(mem_write_o), 256'(0));
                ck("rst_addr", 256'(mem_addr_o), 256'(0));
                ck("rst_wdata", mem_data_o, 256'(0));
                ck("rst_data", 256'(cpu_data_o), 256'(0));
            end else begin
                ck("stall", 256'(cpu_stall_o), 256'(exp_c.stall));
                ck("mem_en", 256'(mem_enable_o), 256'(exp_c.en));
                if (exp_c.en) begin
                    ck("mem_wr", 256'(mem_write_o), 256'(exp_c.wr));
                    ck("mem_addr", 256'(mem_addr_o), 256'(exp_c.addr));
                end
                if (exp_c.chk_wd) ck("mem_wdata", mem_data_o, exp_c.wd);
                if (exp_c.chk_dat) ck("cpu_data", 256'(cpu_data_o), 256'(exp_c.dat));
            end
        end
    end

    task automatic set_exp(input bit stall, input bit en, input bit wr, input logic [31:0] addr);
        exp_c.chk     = 1'b1;
        exp_c.zero    = 1'b0;
        exp_c.stall   = stall;
        exp_c.en      = en;
        exp_c.wr      = wr;
        exp_c.addr    = addr;
        exp_c.chk_wd  = 1'b0;
        exp_c.wd      = '0;
        exp_c.chk_dat = 1'b0;
        exp_c.dat     = '0;
    endtask

    // Acks in cycles without an open transfer must have no effect.
    task automatic rnd_ack();
        mem_ack_i  = ($urandom_range(0, 3) == 0);
        mem_data_i = rnd256();
    endtask

    task automatic cyc();
        @(negedge clk);
        if (cpu_stall_o) obs_stall++;
        if (obs_first) begin
            obs_first_stall = cpu_stall_o;
            obs_first       = 1'b0;
        end
        if (mem_enable_o && mem_write_o) begin
            obs_wb      = 1'b1;
            obs_wb_addr = mem_addr_o;
            obs_wb_w1   = mem_data_o[63:32];
        end
        if (mem_enable_o && !mem_write_o && !obs_alloc) begin
            obs_alloc      = 1'b1;
            obs_alloc_addr = mem_addr_o;
`ifdef DCACHE_STATS_EN
            obs_hits = hit_cnt;
            obs_miss = miss_cnt;
`endif
        end
        if (!cpu_stall_o) obs_data = cpu_data_o;
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
    endtask

    task automatic drop_req();
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
    endtask

    task automatic idle_cyc();
        drop_req();
        set_exp(1'b0, 1'b0, 1'b0, '0);
        exp_c.chk_dat = 1'b1;
        rnd_ack();
        cyc();
        exp_c.chk = 1'b0;
    endtask

    task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdat,
                           input int l1, input int l2, input bit abort);
        logic [3:0]  idx;
        logic [22:0] tg;
        int          w;
        logic [31:0] blk;
        logic [31:0] va;
        bit          hit;
        idx = addr[8:5];
        tg  = addr[31:9];
        w   = int'(addr[4:2]);
        blk = {addr[31:5], 5'b0};
        obs_stall = 0; obs_first = 1'b1; obs_wb = 1'b0; obs_alloc = 1'b0;
        obs_wb_addr = '0; obs_wb_w1 = '0; obs_alloc_addr = '0; obs_data = '0;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        cpu_addr_i     = addr;
        cpu_data_i     = wdat;
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!hit) begin
            set_exp(1'b1, 1'b0, 1'b0, '0);
            rnd_ack();
            cyc();
            if (m_valid[idx] && m_dirty[idx]) begin
                va = {m_tag[idx], idx, 5'b0};
                for (int i = 0; i < l1; i++) begin
                    set_exp(1'b1, 1'b1, 1'b1, va);
                    exp_c.chk_wd = 1'b1;
                    exp_c.wd     = m_data[idx];
                    mem_data_i   = rnd256();
                    mem_ack_i    = (i == l1 - 1);
                    cyc();
                end
                mem[va] = m_data[idx];
            end
            for (int i = 0; i < l2; i++) begin
                if (abort && i == 1) begin
                    rst_i = 1'b0;
                    exp_c.chk  = 1'b1;
                    exp_c.zero = 1'b1;
                    mem_ack_i  = 1'b0;
                    cyc();
                    rst_i   = 1'b1;
                    m_valid = '0;
                    m_dirty = '0;
                    drop_req();
                    set_exp(1'b0, 1'b0, 1'b0, '0);
                    exp_c.chk_dat = 1'b1;
                    mem_data_i    = rnd256();
                    mem_ack_i     = 1'b1;
                    cyc();
                    exp_c.chk = 1'b0;
                    return;
                end
                set_exp(1'b1, 1'b1, 1'b0, blk);
                mem_data_i = mem_rd(blk);
                mem_ack_i  = (i == l2 - 1);
                cyc();
            end
            m_data[idx]  = mem_rd(blk);
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            set_exp(1'b1, 1'b0, 1'b0, '0);
            rnd_ack();
            cyc();
        end
        set_exp(1'b0, 1'b0, 1'b0, '0);
        if (rd && !wr) begin
            exp_c.chk_dat = 1'b1;
            exp_c.dat     = m_data[idx][w*32 +: 32];
        end
        rnd_ack();
        cyc();
        if (wr) begin
            m_data[idx][w*32 +: 32] = wdat;
            m_dirty[idx] = 1'b1;
        end
        drop_req();
        exp_c.chk = 1'b0;
    endtask

    initial begin
        exp_c.chk = 1'b0;
        m_valid = '0;
        m_dirty = '0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        obs_hits = '0;
        obs_miss = '0;

        // Reset with a load pending and stray acks: every output must stay low.
        rst_i          = 1'b0;
        cpu_MemRead_i  = 1'b1;
        cpu_MemWrite_i = 1'b0;
        cpu_addr_i     = 32'h0000_0040;
        cpu_data_i     = '0;
        for (int i = 0; i < 3; i++) begin
            exp_c.chk  = 1'b1;
            exp_c.zero = 1'b1;
            rnd_ack();
            cyc();
        end
        rst_i = 1'b1;
        exp_c.chk = 1'b0;
        idle_cyc();

        // Cold load miss with a 3-cycle fill.
        mem[32'h0000_0040] = 256'h1234;
        run_req(1'b1, 1'b0, 32'h0000_0040, '0, 1, 3, 1'b0);
        ck("miss_stall_cycles", 256'(obs_stall), 256'(5));
        ck("miss_load_data", 256'(obs_data), 256'h1234);
        ck("miss_no_writeback", 256'(obs_wb), 256'(0));

        // Store hit, then load it back.
        run_req(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1, 1, 1'b0);
        ck("store_hit_no_stall", 256'(obs_stall), 256'(0));
        run_req(1'b1, 1'b0, 32'h0000_0044, '0, 1, 1, 1'b0);
        ck("load_after_store", 256'(obs_data), 256'hDEAD_BEEF);
        ck("load_hit_no_stall", 256'(obs_stall), 256'(0));

        // Conflict miss: write back the dirty line, then reset in the middle of the fill.
        run_req(1'b1, 1'b0, 32'h0000_0240, '0, 2, 3, 1'b1);
        ck("wb_seen", 256'(obs_wb), 256'(1));
        ck("wb_addr", 256'(obs_wb_addr), 256'h40);
        ck("wb_word1", 256'(obs_wb_w1), 256'hDEAD_BEEF);
        ck("alloc_addr", 256'(obs_alloc_addr), 256'h240);
`ifdef DCACHE_STATS_EN
        ck("stats_hits", 256'(obs_hits), 256'(3));
        ck("stats_misses", 256'(obs_miss), 256'(2));
`endif
        idle_cyc();

        // Reset invalidated everything: the old line misses again and refills from memory.
        run_req(1'b1, 1'b0, 32'h0000_0040, '0, 1, 2, 1'b0);
        ck("post_reset_miss", 256'(obs_first_stall), 256'(1));
        ck("post_reset_data", 256'(obs_data), 256'h1234);
        ck("post_reset_stall_cycles", 256'(obs_stall), 256'(4));

        // Both request lines high behaves as a store.
        run_req(1'b1, 1'b1, 32'h0000_0048, 32'hCAFE_0001, 1, 1, 1'b0);
        run_req(1'b1, 1'b0, 32'h0000_0048, '0, 1, 1, 1'b0);
        ck("both_high_is_store", 256'(obs_data), 256'hCAFE_0001);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int op;
            if ($urandom_range(0, 3) == 0) begin
                idle_cyc();
            end else begin
                a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) | $urandom_range(0, 31);
                if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
                op = $urandom_range(0, 2);
                run_req(op != 1, op != 0, a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);
            end
        end
        idle_cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
